pipeline_hazard_controller: RTL

//  Central sequencer for the 5-stage pipeline. Drives write-enable, flush and bubble controls for PC, IF/ID, ID/EX,
//  EX/MEM and MEM/WB registers. Covers load-use stalls, taken-branch squash, data-memory wait freeze and halt drain.
//  FSM plus counters. Stall/flush controls are same-cycle combinational from state + inputs; state/counters registered.

---
 rtl/pipeline_hazard_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage pipeline: generates register enables, flushes and
// bubbles for load-use stalls, branch squash, data-memory wait freeze and halt drain.
module pipeline_hazard_controller #(
  parameter int CNT_W        = 32,
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Halt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteRegister,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Access,
  input  logic             MEM_Ready,
  input  logic             Resume,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MEM_WB_Bubble,
  output logic             Halted,
  output logic             MemTimeout,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    LOAD_STALL = 3'd1,
    MEM_WAIT   = 3'd2,
    DRAIN      = 3'd3,
    HALTED     = 3'd4
  } state_t;

  state_t state, stateNext;
  logic [WAIT_W-1:0]  waitCnt, waitNext, waitInc;
  logic [DRAIN_W-1:0] drainCnt, drainNext;
  logic memStall, loadUse;
  logic pcWr, ifIdWr, idExWr, exMemWr, memWbWr, ifIdFl, idExFl, bubble;
  logic flushInc, timeoutSet, timeoutClr;

  assign memStall = MEM_Access & ~MEM_Ready;
  assign loadUse  = EX_MemRead && (EX_WriteRegister != 5'd0) &&
                    ((EX_WriteRegister == ID_Rs) || (ID_UsesRt && (EX_WriteRegister == ID_Rt)));
  assign waitInc  = waitCnt + WAIT_W'(1);

  always_comb begin
    pcWr       = 1'b1;
    ifIdWr     = 1'b1;
    idExWr     = 1'b1;
    exMemWr    = 1'b1;
    memWbWr    = 1'b1;
    ifIdFl     = 1'b0;
    idExFl     = 1'b0;
    bubble     = 1'b0;
    Halted     = 1'b0;
    stateNext  = state;
    waitNext   = waitCnt;
    drainNext  = drainCnt;
    flushInc   = 1'b0;
    timeoutSet = 1'b0;
    timeoutClr = 1'b0;

    case (state)
      // MEM_WAIT without a pending miss behaves exactly like RUN
      RUN, MEM_WAIT: begin
        if (memStall) begin
          {pcWr, ifIdWr, idExWr, exMemWr} = 4'b0000;
          bubble = 1'b1;
          if (state == RUN) begin
            waitNext  = WAIT_W'(1);
            stateNext = MEM_WAIT;
          end else begin
            waitNext = waitInc;
            if (waitInc == WAIT_W'(MEM_TIMEOUT)) begin
              timeoutSet = 1'b1;
              stateNext  = HALTED;
            end
          end
        end else begin
          waitNext  = '0;
          stateNext = RUN;
          if (EX_BranchTaken) begin
            ifIdFl   = 1'b1;
            idExFl   = 1'b1;
            flushInc = 1'b1;
          end else if (loadUse) begin
            pcWr      = 1'b0;
            ifIdWr    = 1'b0;
            idExFl    = 1'b1;
            stateNext = LOAD_STALL;
          end else if (ID_Halt) begin
            pcWr      = 1'b0;
            ifIdFl    = 1'b1;
            drainNext = '0;
            stateNext = DRAIN;
          end
        end
      end
      LOAD_STALL: begin
        if (memStall) begin
          {pcWr, ifIdWr, idExWr, exMemWr} = 4'b0000;
          bubble    = 1'b1;
          waitNext  = WAIT_W'(1);
          stateNext = MEM_WAIT;
        end else begin
          stateNext = RUN;
        end
      end
      // Nothing younger than the halt is valid, so branches are ignored here
      DRAIN: begin
        pcWr   = 1'b0;
        ifIdFl = 1'b1;
        if (memStall) begin
          {ifIdWr, idExWr, exMemWr} = 3'b000;
          bubble = 1'b1;
        end else begin
          drainNext = drainCnt + DRAIN_W'(1);
          if (drainCnt == DRAIN_W'(DRAIN_CYCLES - 1)) stateNext = HALTED;
        end
      end
      HALTED: begin
        {pcWr, ifIdWr, idExWr, exMemWr, memWbWr} = 5'b00000;
        Halted = 1'b1;
        if (Resume) begin
          timeoutClr = 1'b1;
          waitNext   = '0;
          drainNext  = '0;
          stateNext  = RUN;
        end
      end
      default: stateNext = RUN;
    endcase

    PCWrite       = pcWr;
    IF_ID_Write   = ifIdWr;
    ID_EX_Write   = idExWr;
    EX_MEM_Write  = exMemWr;
    MEM_WB_Write  = memWbWr;
    IF_ID_Flush   = ifIdFl;
    ID_EX_Flush   = idExFl;
    MEM_WB_Bubble = bubble;
    // Held reset parks every register on a NOP regardless of the decoded state
    if (reset) begin
      {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write} = 5'b00000;
      {IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble} = 3'b111;
      Halted = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      waitCnt    <= '0;
      drainCnt   <= '0;
      MemTimeout <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state    <= stateNext;
      waitCnt  <= waitNext;
      drainCnt <= drainNext;
      if (timeoutSet) MemTimeout <= 1'b1;
      else if (timeoutClr) MemTimeout <= 1'b0;
      if (!pcWr && state != HALTED && StallCount != '1) StallCount <= StallCount + CNT_W'(1);
      if (flushInc && FlushCount != '1) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

  assign State = state;

endmodule
